// File: rtl/chip_buf_if.sv
// chip_buf_if
//   Groups the two streams around the chip record buffer.
//   Sample side : d1_data, d1_vld, sel_path, cfg_len toward the buffer,
//                 buf_rdy back to the chip-path selector.
//   Packet side : tx_data, tx_vld, tx_sop, tx_eop from the buffer,
//                 tx_rdy back from the host-link packetiser.
//   The master modport is the environment (selector + packetiser); the
//   slave modport is the buffer itself.
interface chip_buf_if;
  logic [15:0] d1_data;
  logic        d1_vld;
  logic [6:0]  sel_path;
  logic [19:0] cfg_len;
  logic        buf_rdy;
  logic [15:0] tx_data;
  logic        tx_vld;
  logic        tx_rdy;
  logic        tx_sop;
  logic        tx_eop;

  modport master (
    output d1_data, d1_vld, sel_path, cfg_len, tx_rdy,
    input  buf_rdy, tx_data, tx_vld, tx_sop, tx_eop
  );

  modport slave (
    input  d1_data, d1_vld, sel_path, cfg_len, tx_rdy,
    output buf_rdy, tx_data, tx_vld, tx_sop, tx_eop
  );
endinterface

// File: rtl/chip_buf.sv
// chip_buf
//   Captures one chip record from the chip-path selector into on-chip RAM,
//   then replays it as a framed packet: header {HDR_TAG, trunc, path},
//   length word, then the stored samples. Records longer than the RAM are
//   still fully consumed from the selector; the excess samples are dropped.
// Ports:
//   clk_sys   system clock
//   rst       asynchronous reset, active-high
//   bus       chip_buf_if.slave: sample stream in (d1_*, sel_path, cfg_len,
//             buf_rdy) and packet stream out (tx_*)
//   chip_cnt  number of completed records, wraps at 16 bits
module chip_buf #(
  parameter int unsigned AW      = 12,
  parameter logic [7:0]  HDR_TAG = 8'hA5
) (
  input  logic        clk_sys,
  input  logic        rst,
  chip_buf_if.slave   bus,
  output logic [15:0] chip_cnt
);

  localparam int unsigned DEPTH   = 1 << AW;
  localparam logic [20:0] DEPTH_W = 21'(DEPTH);

  typedef enum logic [2:0] {IDLE, CAP, DRAIN, HDR, LEN, DAT} state_t;

  state_t      state;
  state_t      state_nxt;

  logic [19:0] len_l;
  logic [19:0] len_s;
  logic        trunc;
  logic [6:0]  path;
  logic [19:0] count;
  logic [19:0] rd_idx;
  logic        buf_rdy_q;

  logic [15:0] mem [DEPTH];
  logic [15:0] ram_q;

  logic        acc;
  logic        wen;
  logic        ren;
  logic        last_word;
  logic [AW-1:0] waddr;
  logic [AW-1:0] raddr;
  logic [19:0] l_in;
  logic [19:0] s_in;
  logic        t_in;
  logic [19:0] count_inc;
  logic [19:0] rd_inc;

  logic [15:0] tx_data_c;
  logic        tx_vld_c;
  logic        tx_sop_c;
  logic        tx_eop_c;

  // buf_rdy is only high in capture states, so an accepted sample always
  // belongs to IDLE, CAP or DRAIN.
  assign acc       = bus.d1_vld & buf_rdy_q;
  assign count_inc = count + 20'd1;
  assign rd_inc    = rd_idx + 20'd1;
  assign last_word = (rd_idx == len_s - 20'd1);

  // A zero length is treated as a single-sample record.
  assign l_in = (bus.cfg_len == 20'd0) ? 20'd1 : bus.cfg_len;
  assign t_in = ({1'b0, l_in} > DEPTH_W);
  assign s_in = t_in ? DEPTH_W[19:0] : l_in;

  assign wen   = acc && ((state == IDLE) || (state == CAP));
  assign waddr = (state == IDLE) ? '0 : count[AW-1:0];

  assign bus.buf_rdy = buf_rdy_q;
  assign bus.tx_data = tx_data_c;
  assign bus.tx_vld  = tx_vld_c;
  assign bus.tx_sop  = tx_sop_c;
  assign bus.tx_eop  = tx_eop_c;

  // State register.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and packet outputs. The packet words are decoded straight
  // from the state, so tx_vld rises in the cycle after the last sample and
  // drops the instant reset asserts. The RAM read for data word 0 is issued
  // on the length handshake, and each following read only on a data
  // handshake, so ram_q doubles as the hold register during stalls.
  always_comb begin
    state_nxt = state;
    tx_data_c = '0;
    tx_vld_c  = 1'b0;
    tx_sop_c  = 1'b0;
    tx_eop_c  = 1'b0;
    ren       = 1'b0;
    raddr     = '0;
    case (state)
      IDLE: begin
        if (acc) begin
          state_nxt = (l_in == 20'd1) ? HDR : CAP;
        end
      end
      CAP: begin
        if (acc && (count_inc == len_s)) begin
          state_nxt = (len_l == len_s) ? HDR : DRAIN;
        end
      end
      DRAIN: begin
        if (acc && (count_inc == len_l)) begin
          state_nxt = HDR;
        end
      end
      HDR: begin
        tx_vld_c  = 1'b1;
        tx_sop_c  = 1'b1;
        tx_data_c = {HDR_TAG, trunc, path};
        if (bus.tx_rdy) begin
          state_nxt = LEN;
        end
      end
      LEN: begin
        tx_vld_c  = 1'b1;
        tx_data_c = len_s[15:0];
        if (bus.tx_rdy) begin
          state_nxt = DAT;
          ren       = 1'b1;
          raddr     = '0;
        end
      end
      DAT: begin
        tx_vld_c  = 1'b1;
        tx_eop_c  = last_word;
        tx_data_c = ram_q;
        if (bus.tx_rdy) begin
          if (last_word) begin
            state_nxt = IDLE;
          end else begin
            ren   = 1'b1;
            raddr = rd_inc[AW-1:0];
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Record bookkeeping: length/path latch on the first sample, sample count,
  // readout index and completed-record counter. buf_rdy follows the state
  // being entered so it is low for the whole readout.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      len_l     <= '0;
      len_s     <= '0;
      trunc     <= 1'b0;
      path      <= '0;
      count     <= '0;
      rd_idx    <= '0;
      chip_cnt  <= '0;
      buf_rdy_q <= 1'b0;
    end else begin
      buf_rdy_q <= (state_nxt == IDLE) || (state_nxt == CAP) || (state_nxt == DRAIN);
      if ((state == IDLE) && acc) begin
        len_l <= l_in;
        len_s <= s_in;
        trunc <= t_in;
        path  <= bus.sel_path;
        count <= 20'd1;
      end else if (((state == CAP) || (state == DRAIN)) && acc) begin
        count <= count_inc;
      end
      if ((state == LEN) && bus.tx_rdy) begin
        rd_idx <= '0;
      end else if ((state == DAT) && bus.tx_rdy) begin
        rd_idx <= rd_inc;
      end
      if ((state == DAT) && bus.tx_rdy && last_word) begin
        chip_cnt <= chip_cnt + 16'd1;
      end
    end
  end

  // Sample RAM with registered, enabled read port.
  always_ff @(posedge clk_sys) begin
    if (wen) begin
      mem[waddr] <= bus.d1_data;
    end
    if (ren) begin
      ram_q <= mem[raddr];
    end
  end

endmodule

// File: tb/tb_chip_buf.sv
// tb_chip_buf
//   Self-checking bench for chip_buf built with a small RAM (AW=3, 8 words)
//   so record truncation is reachable. A reference model turns each record
//   (length, path, samples) into the expected packet words; a monitor
//   collects every transferred word and checks that stalled words hold.
module tb_chip_buf;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic [15:0] chip_cnt;

  chip_buf_if bus();

  chip_buf #(.AW(AW), .HDR_TAG(8'hA5)) dut (
    .clk_sys  (clk_sys),
    .rst      (rst),
    .bus      (bus),
    .chip_cnt (chip_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  int          checks = 0;
  int          errors = 0;
  int          rdy_mode = 0;
  logic [17:0] got_q[$];
  logic [17:0] exp_q[$];
  logic [15:0] smp[$];
  logic [15:0] cnt_model = 16'd0;

  // Downstream ready: 0 = always ready, 1 = toggling, 2 = random.
  initial begin
    bus.tx_rdy = 1'b1;
    forever begin
      @(posedge clk_sys);
      #1;
      case (rdy_mode)
        0:       bus.tx_rdy = 1'b1;
        1:       bus.tx_rdy = ~bus.tx_rdy;
        default: bus.tx_rdy = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Word collector and stall-hold checker, sampled on the falling edge.
  initial begin : monitor
    logic        stalled;
    logic [17:0] held;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk_sys);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          checks++;
          if (bus.tx_vld !== 1'b1 || {bus.tx_sop, bus.tx_eop, bus.tx_data} !== held) begin
            errors++;
            $display("[TB] FAIL stall_hold: got vld=%b word=%h, required vld=1 word=%h",
                     bus.tx_vld, {bus.tx_sop, bus.tx_eop, bus.tx_data}, held);
          end
        end
        if (bus.tx_vld === 1'b1 && bus.tx_rdy === 1'b1) begin
          got_q.push_back({bus.tx_sop, bus.tx_eop, bus.tx_data});
        end
        stalled = (bus.tx_vld === 1'b1) && (bus.tx_rdy !== 1'b1);
        held    = {bus.tx_sop, bus.tx_eop, bus.tx_data};
      end
    end
  end

  // Reference model: appends the packet for one record, as {sop, eop, data}.
  task automatic model_packet(input logic [19:0] cfg, input logic [6:0] path);
    int   l;
    int   s;
    logic t;
    l = (cfg == 20'd0) ? 1 : int'(cfg);
    t = (l > DEPTH);
    s = t ? DEPTH : l;
    exp_q.push_back({2'b10, 8'hA5, t, path});
    exp_q.push_back({2'b00, 16'(s)});
    for (int i = 0; i < s; i++) begin
      exp_q.push_back({1'b0, (i == s - 1), smp[i]});
    end
  endtask

  // Presents the samples in smp, each held until accepted. Reports how many
  // sampled cycles showed tx_vld high and how many waited on buf_rdy.
  task automatic send_record(input logic [19:0] cfg, input logic [6:0] path, input int gap,
                             input bit rnd_path, output int early, output int waits);
    int n;
    int guard;
    bit taken;
    n     = (cfg == 20'd0) ? 1 : int'(cfg);
    early = 0;
    waits = 0;
    bus.cfg_len = cfg;
    for (int i = 0; i < n; i++) begin
      bus.d1_data  = smp[i];
      bus.d1_vld   = 1'b1;
      bus.sel_path = (i == 0 || !rnd_path) ? path : 7'($urandom);
      taken = 1'b0;
      guard = 0;
      while (!taken && guard < 200) begin
        @(negedge clk_sys);
        if (bus.tx_vld === 1'b1) early++;
        taken = (bus.buf_rdy === 1'b1);
        if (!taken) waits++;
        @(posedge clk_sys);
        #1;
        guard++;
      end
      bus.d1_vld = 1'b0;
      if (!taken) begin
        checks++;
        errors++;
        $display("[TB] FAIL send_timeout: sample %0d got buf_rdy=%b, required 1", i, bus.buf_rdy);
        return;
      end
      if (i < n - 1) begin
        repeat (gap) begin
          @(posedge clk_sys);
          #1;
        end
      end
    end
  endtask

  task automatic wait_words(input int n, output bit ok);
    int guard;
    guard = 0;
    while (got_q.size() < n && guard < 500) begin
      @(posedge clk_sys);
      #1;
      guard++;
    end
    ok = (got_q.size() >= n);
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk_sys);
    #1;
    checks++;
    if ({bus.buf_rdy, bus.tx_vld, bus.tx_sop, bus.tx_eop} !== 4'b0 || bus.tx_data !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got rdy/vld/sop/eop=%b data=%h, required 0000 0000",
               {bus.buf_rdy, bus.tx_vld, bus.tx_sop, bus.tx_eop}, bus.tx_data);
    end
    checks++;
    if (chip_cnt !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_chip_cnt: got %h, required 0000", chip_cnt);
    end
    rst = 1'b0;
    @(negedge clk_sys);
    checks++;
    if (bus.buf_rdy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_rdy_before_edge: got %b, required 0", bus.buf_rdy);
    end
    @(posedge clk_sys);
    #1;
    @(negedge clk_sys);
    checks++;
    if (bus.buf_rdy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_rdy_after_edge: got %b, required 1", bus.buf_rdy);
    end
    @(posedge clk_sys);
    #1;
  endtask

  task automatic test_basic;
    int early;
    int waits;
    bit ok;
    rdy_mode = 0;
    smp = '{16'h0100, 16'h0101, 16'h0102, 16'h0103};
    exp_q.delete();
    got_q.delete();
    model_packet(20'd4, 7'd3);
    send_record(20'd4, 7'd3, 0, 1'b0, early, waits);
    checks++;
    if (waits !== 0 || early !== 0) begin
      errors++;
      $display("[TB] FAIL basic_capture: got waits=%0d early=%0d, required 0 0", waits, early);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_sys);
      checks++;
      if (bus.buf_rdy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL basic_rdy_low: cycle %0d got %b, required 0", k, bus.buf_rdy);
      end
      @(posedge clk_sys);
      #1;
    end
    cnt_model++;
    @(negedge clk_sys);
    checks++;
    if (bus.buf_rdy !== 1'b1 || chip_cnt !== cnt_model) begin
      errors++;
      $display("[TB] FAIL basic_done: got rdy=%b cnt=%0d, required 1 %0d", bus.buf_rdy, chip_cnt, cnt_model);
    end
    @(posedge clk_sys);
    #1;
    wait_words(exp_q.size(), ok);
    checks++;
    if (!ok || got_q.size() != exp_q.size()) begin
      errors++;
      $display("[TB] FAIL basic_count: got %0d words, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL basic_word %0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    int early;
    int waits;
    bit ok;
    rdy_mode = 1;
    smp = '{16'h0100, 16'h0101, 16'h0102, 16'h0103};
    exp_q.delete();
    got_q.delete();
    model_packet(20'd4, 7'd3);
    send_record(20'd4, 7'd3, 0, 1'b0, early, waits);
    wait_words(exp_q.size(), ok);
    cnt_model++;
    checks++;
    if (!ok || got_q.size() != exp_q.size()) begin
      errors++;
      $display("[TB] FAIL bp_count: got %0d words, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL bp_word %0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (chip_cnt !== cnt_model) begin
      errors++;
      $display("[TB] FAIL bp_chip_cnt: got %0d, required %0d", chip_cnt, cnt_model);
    end
    rdy_mode = 0;
  endtask

  task automatic test_sparse;
    int early;
    int waits;
    bit ok;
    smp = '{16'hFFF0, 16'hFFF1, 16'hFFF2, 16'hFFF3, 16'hFFF4};
    exp_q.delete();
    got_q.delete();
    model_packet(20'd5, 7'd7);
    send_record(20'd5, 7'd7, 2, 1'b0, early, waits);
    checks++;
    if (early !== 0) begin
      errors++;
      $display("[TB] FAIL sparse_early_hdr: got %0d valid cycles, required 0", early);
    end
    wait_words(exp_q.size(), ok);
    cnt_model++;
    checks++;
    if (!ok || got_q.size() != exp_q.size()) begin
      errors++;
      $display("[TB] FAIL sparse_count: got %0d words, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL sparse_word %0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_truncation;
    int early;
    int waits;
    bit ok;
    smp.delete();
    for (int i = 0; i < 10; i++) smp.push_back(16'(i));
    exp_q.delete();
    got_q.delete();
    model_packet(20'd10, 7'd1);
    send_record(20'd10, 7'd1, 0, 1'b0, early, waits);
    checks++;
    if (waits !== 0) begin
      errors++;
      $display("[TB] FAIL trunc_drain_rdy: got %0d stalled samples, required 0", waits);
    end
    wait_words(exp_q.size(), ok);
    cnt_model++;
    checks++;
    if (!ok || got_q.size() != exp_q.size()) begin
      errors++;
      $display("[TB] FAIL trunc_count: got %0d words, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL trunc_word %0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_edge_length;
    int early;
    int waits;
    bit ok;
    smp = '{16'h1234};
    exp_q.delete();
    got_q.delete();
    model_packet(20'd0, 7'd0);
    send_record(20'd0, 7'd0, 0, 1'b0, early, waits);
    wait_words(exp_q.size(), ok);
    cnt_model++;
    checks++;
    if (!ok || got_q.size() != exp_q.size()) begin
      errors++;
      $display("[TB] FAIL edge_count: got %0d words, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL edge_word %0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (chip_cnt !== cnt_model) begin
      errors++;
      $display("[TB] FAIL edge_chip_cnt: got %0d, required %0d", chip_cnt, cnt_model);
    end
  endtask

  task automatic test_back_to_back;
    int early;
    int waits;
    bit ok;
    exp_q.delete();
    got_q.delete();
    smp = '{16'hA001, 16'hA002, 16'hA003};
    model_packet(20'd3, 7'd9);
    send_record(20'd3, 7'd9, 0, 1'b0, early, waits);
    smp = '{16'hB001, 16'hB002};
    model_packet(20'd2, 7'h55);
    send_record(20'd2, 7'h55, 0, 1'b0, early, waits);
    // The second record must wait out the first packet: 3 data + 2 framing words.
    checks++;
    if (waits !== 5) begin
      errors++;
      $display("[TB] FAIL b2b_throttle: got %0d stalled cycles, required 5", waits);
    end
    wait_words(exp_q.size(), ok);
    cnt_model += 16'd2;
    checks++;
    if (!ok || got_q.size() != exp_q.size()) begin
      errors++;
      $display("[TB] FAIL b2b_count: got %0d words, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL b2b_word %0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (chip_cnt !== cnt_model) begin
      errors++;
      $display("[TB] FAIL b2b_chip_cnt: got %0d, required %0d", chip_cnt, cnt_model);
    end
  endtask

  task automatic test_reset_mid;
    int early;
    int waits;
    bit ok;
    rdy_mode = 0;
    smp = '{16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3};
    exp_q.delete();
    got_q.delete();
    send_record(20'd4, 7'd5, 0, 1'b0, early, waits);
    wait_words(4, ok);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.tx_vld !== 1'b0 || bus.buf_rdy !== 1'b0 || chip_cnt !== 16'h0) begin
      errors++;
      $display("[TB] FAIL rst_mid_outputs: got vld=%b rdy=%b cnt=%0d, required 0 0 0",
               bus.tx_vld, bus.buf_rdy, chip_cnt);
    end
    cnt_model = 16'd0;
    repeat (2) @(posedge clk_sys);
    #1;
    rst = 1'b0;
    @(posedge clk_sys);
    #1;
    got_q.delete();
    smp = '{16'hBEEF, 16'h0042};
    model_packet(20'd2, 7'd2);
    send_record(20'd2, 7'd2, 0, 1'b0, early, waits);
    wait_words(exp_q.size(), ok);
    cnt_model++;
    checks++;
    if (!ok || got_q.size() != exp_q.size()) begin
      errors++;
      $display("[TB] FAIL rst_mid_count: got %0d words, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL rst_mid_word %0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (chip_cnt !== cnt_model) begin
      errors++;
      $display("[TB] FAIL rst_mid_chip_cnt: got %0d, required %0d", chip_cnt, cnt_model);
    end
  endtask

  task automatic test_random;
    int          early;
    int          waits;
    bit          ok;
    logic [19:0] cfg;
    logic [6:0]  path;
    int          n;
    int          gap;
    rdy_mode = 2;
    for (int r = 0; r < 24; r++) begin
      cfg  = 20'($urandom_range(0, 12));
      path = 7'($urandom);
      gap  = $urandom_range(0, 2);
      n    = (cfg == 20'd0) ? 1 : int'(cfg);
      smp.delete();
      for (int i = 0; i < n; i++) smp.push_back(16'($urandom));
      exp_q.delete();
      got_q.delete();
      model_packet(cfg, path);
      send_record(cfg, path, gap, 1'b1, early, waits);
      wait_words(exp_q.size(), ok);
      cnt_model++;
      checks++;
      if (!ok || got_q.size() != exp_q.size()) begin
        errors++;
        $display("[TB] FAIL rand_count rec %0d: got %0d words, required %0d", r, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("[TB] FAIL rand_word rec %0d word %0d: got %h, required %h", r, i, got_q[i], exp_q[i]);
        end
      end
      checks++;
      if (chip_cnt !== cnt_model) begin
        errors++;
        $display("[TB] FAIL rand_chip_cnt rec %0d: got %0d, required %0d", r, chip_cnt, cnt_model);
      end
    end
    rdy_mode = 0;
  endtask

  initial begin
    rst          = 1'b1;
    bus.d1_vld   = 1'b0;
    bus.d1_data  = '0;
    bus.sel_path = '0;
    bus.cfg_len  = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_sparse();
    test_truncation();
    test_edge_length();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chip_buf.md
Name: chip_buf

Overview:
- Downstream consumer of the chip-path selector output.
- Accepts the gated sample stream (d1_data/d1_vld) plus the latched channel index (sel_path), and drives buf_rdy back to throttle the selector.
- Stores one chip record in on-chip RAM, then emits it as a framed 16-bit packet (header, length, samples) on a valid/ready stream toward the host-link packetiser.
- Throttling by buf_rdy freezes the selector's length counter, so no sample is lost while the buffer drains.

Parameters:
- AW, 12, RAM address width; capacity DEPTH = 2^AW words (4096).
- HDR_TAG, 8'hA5, upper byte of the header word.

Ports:
- clk_sys  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- d1_data  in  16  sample from chip-path selector.
- d1_vld  in  1  sample valid; a sample is consumed only when d1_vld & buf_rdy.
- sel_path  in  7  selected channel index; constant for a record.
- cfg_len  in  20  record length in samples; same value as programmed into the selector.
- buf_rdy  out  1  buffer accepting samples.
- tx_data  out  16  output packet word.
- tx_vld  out  1  output word valid.
- tx_rdy  in  1  downstream ready; word transfers when tx_vld & tx_rdy.
- tx_sop  out  1  first word of packet (header).
- tx_eop  out  1  last word of packet.
- chip_cnt  out  16  completed records; wraps 0xFFFF->0.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; buf_rdy, tx_vld, tx_sop, tx_eop, tx_data, chip_cnt all 0; any partial record is discarded.
  - buf_rdy = 1 from the first clk_sys edge after release.
- buf_rdy is registered. It is 1 in IDLE, CAP and DRAIN, and 0 in HDR, LEN and DAT.
- Length latch:
  - Taken on the first accepted sample in IDLE: L = cfg_len, with cfg_len = 0 treated as 1.
  - Stored length S = min(L, DEPTH).
  - Trunc flag T = (L > DEPTH).
  - sel_path is latched on the same cycle.
- IDLE: an accepted sample is written to address 0 and the accepted-sample count is set to 1.
  - If L == 1, go to HDR; otherwise go to CAP.
- CAP: each accepted sample is written to address = count, then count increments.
  - When count reaches S: go to HDR if L == S, otherwise go to DRAIN.
  - Cycles with d1_vld = 0 are idle and do not time out.
- DRAIN: accepted samples are counted but not stored. When count reaches L, go to HDR.
- HDR: drive tx_data = {HDR_TAG, T, sel_path_latched} with tx_sop = 1.
  - tx_vld is asserted in the cycle after the last sample is accepted, and buf_rdy is 0 in that same cycle.
- LEN: drive tx_data = S[15:0].
- DAT: drive RAM words 0..S-1 in order; tx_eop = 1 on word S-1.
  - On the eop handshake: chip_cnt increments, go to IDLE, and buf_rdy = 1 on the next cycle.
- Stream rules:
  - While tx_vld is high and tx_rdy is low, tx_data, tx_sop and tx_eop hold stable.
  - tx_vld never deasserts without a handshake.
  - With tx_rdy held at 1, the packet is S+2 consecutive words with no bubbles. RAM has 1-cycle read latency, so the implementation must prefetch during HDR/LEN and keep a skid register for stalls.
- Address and count widths:
  - Count is 20 bits; it is compared against L and S in 20 bits.
  - RAM address is AW bits.
- Samples presented while buf_rdy = 0 are ignored. The selector does not advance on them.
- sel_path changes during a record are ignored; the value latched at record start is used.

Test Plan:
- Basic record: cfg_len=4, sel_path=3, samples 0x0100..0x0103 on consecutive cycles, tx_rdy=1.
  - Stream is 0xA503(sop), 0x0004, 0x0100, 0x0101, 0x0102, 0x0103(eop).
  - buf_rdy is 0 from the cycle after the 4th sample until the cycle after eop.
  - chip_cnt=1.
- Backpressure: same record with tx_rdy toggling 1,0,1,0…
  - Identical 6-word sequence.
  - tx_data, tx_sop and tx_eop are stable on every stalled cycle, with no duplicated or dropped words.
- Sparse input: d1_vld high every 3rd cycle, cfg_len=5, sel_path=7, data 0xFFF0..0xFFF4.
  - Stream is 0xA507, 0x0005, 0xFFF0..0xFFF4.
  - No header before the 5th sample.
- Truncation: AW=3 (DEPTH=8), cfg_len=10, sel_path=1, data 0..9.
  - All 10 samples are accepted (buf_rdy stays 1 through DRAIN).
  - Stream is 0xA581, 0x0008, 0x0000..0x0007.
- Edge length: cfg_len=0, one sample 0x1234 with sel_path=0.
  - Stream is 0xA500, 0x0001, 0x1234 (sop on first word, eop on last word).
- Reset mid-readout: assert rst while in DAT after 2 data words.
  - tx_vld and buf_rdy go 0 immediately; chip_cnt=0.
  - After release, a new cfg_len=2 record streams cleanly with a fresh header.
